vadd_seq_ctrl: RTL and testbench
================================

VADD_SEQ_CTRL -- requirements
Module: vadd_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, operand/result beat width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, beat address width.
REQ-003 SHALL have parameter VL_WIDTH, default 16, element-count width.
REQ-004 SHALL have parameter OPSEL_WIDTH, default 9, add/min-max unit op select width.
REQ-005 SHALL have parameter PIPE_LAT, default 6, fixed add/min-max unit issue-to-result latency in cycles.
REQ-006 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller can accept a command.
- cmd_vl  in  VL_WIDTH  element count.
- cmd_sew  in  2  element width: 0=8b, 1=16b, 2=32b, 3=64b.
- cmd_opSel  in  OPSEL_WIDTH  op select; bit 8 = mask-producing compare.
- cmd_addr  in  ADDR_WIDTH  destination base beat address.
- cmd_avg  in  1  averaging (fixed-point) op.
- iss_stall  in  1  operands not available this cycle.
- abort  in  1  kill the current sequence.
- iss_valid  out  1  beat issued to unit (unit in_valid).
- iss_sew, iss_opSel, iss_avg  out  2/OPSEL_WIDTH/1  captured command fields.
- iss_addr  out  ADDR_WIDTH  beat destination address.
- iss_start_idx  out  6  mask bit position.
- iss_req_start, iss_req_end  out  1  first/last beat of sequence.
- iss_be  out  DATA_WIDTH/8  byte enables.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle completion pulse.

Function
REQ-007 SHALL implement states IDLE, ISSUE, DRAIN; cmd_ready=1 only in IDLE.
REQ-008 SHALL capture all cmd_* fields on cmd_valid&cmd_ready and hold them until the next acceptance.
REQ-009 SHALL compute EPB=(DATA_WIDTH/8)>>sew elements per beat and NB=ceil(vl/EPB) beats.
REQ-010 SHALL on acceptance with vl>0 enter ISSUE; first beat SHALL be issued the cycle after acceptance.
REQ-011 SHALL on acceptance with vl=0 issue no beat and assert done exactly one cycle after acceptance, remaining in IDLE.
REQ-012 SHALL in ISSUE assert iss_valid and advance beat index b each cycle iss_stall=0; with iss_stall=1, iss_valid=0 and b holds.
REQ-013 SHALL drive iss_req_start=1 only on b=0 and iss_req_end=1 only on b=NB-1 (both on a one-beat sequence), qualified by iss_valid.
REQ-014 SHALL drive iss_be all ones, except on the last beat when r=vl-b*EPB<EPB: low (r<<sew) bits set.
REQ-015 SHALL, for non-mask ops, drive iss_addr=cmd_addr+b and iss_start_idx=0.
REQ-016 SHALL, for mask ops (opSel[8]=1), drive iss_start_idx=(b*EPB) mod 64 and iss_addr=cmd_addr+((b*EPB)>>6).
REQ-017 SHALL enter DRAIN after issuing beat NB-1 in cycle T, and assert done in cycle T+PIPE_LAT, entering IDLE on the same edge (cmd_ready=1 from cycle T+PIPE_LAT).
REQ-018 SHALL hold iss_valid=0 and all iss_* qualifiers 0 outside ISSUE.
REQ-019 SHALL on abort=1 in ISSUE or DRAIN go to IDLE next edge with no done pulse; abort SHALL take priority over iss_stall and completion.
REQ-020 SHALL ignore abort in IDLE; abort coincident with acceptance SHALL NOT cancel the new command.
REQ-021 SHALL use beat counter width sufficient for ceil((2^VL_WIDTH-1)/1) beats without wrap; address arithmetic wraps modulo 2^ADDR_WIDTH.

Reset
REQ-022 SHALL on rst=1 immediately force state IDLE, cmd_ready=0, iss_valid=0, busy=0, done=0, all other outputs and captured fields 0.
REQ-023 SHALL assert cmd_ready the first cycle after rst deasserts; reset mid-sequence SHALL discard it with no done.

Verification
REQ-024 sew=0, vl=20, addr=0x100, non-mask -> 3 beats on consecutive cycles, iss_addr 0x100/0x101/0x102, iss_be FF/FF/0F, req_start beat0, req_end beat2, done exactly PIPE_LAT cycles after beat2.
REQ-025 sew=3, vl=3, iss_stall=1 for one cycle after beat0 -> iss_valid gap of one cycle, beats addr+0/+1/+2 each once, all be=FF, done shifted by one cycle.
REQ-026 mask op, sew=0, vl=200, addr=0x40 -> 25 beats, start_idx 0,8,..,56 repeating, iss_addr 0x40 for b0-7, 0x41 for b8-15, 0x43 for b24, last be=FF.
REQ-027 vl=0 -> no iss_valid, done one cycle after acceptance, cmd_ready stays 1.
REQ-028 abort during beat 1 of a 3-beat command, then immediate new command -> no done for first, second completes normally; rst asserted mid-ISSUE -> all outputs 0 same cycle, no done.

Source files
------------

// File: rtl/vadd_seq_ctrl.sv
// Purpose: sequences one vector add/min-max command into per-beat issues to a
//          fixed-latency arithmetic unit, then waits out the pipeline and pulses done.
// Latency: first beat the cycle after acceptance; done PIPE_LAT cycles after the last beat.
// Backpressure: cmd_ready only in IDLE; iss_stall freezes the beat index and drops iss_valid.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_vl/sew/opSel/addr/avg   command fields, captured on acceptance
//   iss_stall, abort            operand stall, kill current sequence
//   iss_valid                   beat issued to the unit this cycle
//   iss_sew/opSel/avg           captured command fields (zero outside ISSUE)
//   iss_addr, iss_start_idx     beat destination address, mask bit position
//   iss_req_start/iss_req_end   first/last beat markers, qualified by iss_valid
//   iss_be                      byte enables of the beat
//   busy, done                  not-IDLE status, one-cycle completion pulse
module vadd_seq_ctrl #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int VL_WIDTH    = 16,
  parameter int OPSEL_WIDTH = 9,
  parameter int PIPE_LAT    = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [VL_WIDTH-1:0]     cmd_vl,
  input  logic [1:0]              cmd_sew,
  input  logic [OPSEL_WIDTH-1:0]  cmd_opSel,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic                    cmd_avg,
  input  logic                    iss_stall,
  input  logic                    abort,
  output logic                    iss_valid,
  output logic [1:0]              iss_sew,
  output logic [OPSEL_WIDTH-1:0]  iss_opSel,
  output logic                    iss_avg,
  output logic [ADDR_WIDTH-1:0]   iss_addr,
  output logic [5:0]              iss_start_idx,
  output logic                    iss_req_start,
  output logic                    iss_req_end,
  output logic [DATA_WIDTH/8-1:0] iss_be,
  output logic                    busy,
  output logic                    done
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int LG_BYTES = $clog2(BYTES);
  localparam int LG_W     = 4;
  // b*EPB needs VL_WIDTH+LG_BYTES bits; keep at least 7 so the mask word/bit split is legal.
  localparam int PROD_W   = VL_WIDTH + LG_BYTES;
  localparam int PW       = (PROD_W > 7) ? PROD_W : 7;
  localparam int DCNT_W   = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT + 1);
  // Bit of opSel that marks a mask-producing compare.
  localparam int MASK_BIT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                 state_q;
  logic [VL_WIDTH-1:0]    b_q;
  logic [VL_WIDTH-1:0]    nb_q;
  logic [DCNT_W-1:0]      dcnt_q;
  logic                   done_q;
  logic [VL_WIDTH-1:0]    vl_q;
  logic [1:0]             sew_q;
  logic [OPSEL_WIDTH-1:0] opsel_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   avg_q;

  logic                   accept;
  logic                   in_issue;
  logic                   last_beat;
  logic [LG_W-1:0]        lg_cmd;
  logic [LG_W-1:0]        lg_q;
  logic [VL_WIDTH:0]      nb_sum;
  logic [VL_WIDTH-1:0]    nb_d;
  logic [PW-1:0]          prod;
  logic [PW-1:0]          rem;
  logic [PW-1:0]          epb_q;
  logic [PW+2:0]          nbytes;
  logic                   partial;
  logic [BYTES-1:0]       be_part;

  // The reset term keeps ready low while rst is held even though state is already IDLE.
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign in_issue  = (state_q == ISSUE);
  assign last_beat = (b_q == (nb_q - VL_WIDTH'(1)));

  // log2(elements per beat); clamped at 0 so a too-wide element still yields one per beat.
  always_comb begin
    lg_cmd = '0;
    if (LG_BYTES > int'(cmd_sew)) lg_cmd = LG_W'(LG_BYTES - int'(cmd_sew));
    lg_q = '0;
    if (LG_BYTES > int'(sew_q)) lg_q = LG_W'(LG_BYTES - int'(sew_q));
  end

  // Beat count ceil(vl/EPB), computed from the incoming command so it is ready at beat 0.
  always_comb begin
    nb_sum = {1'b0, cmd_vl} + (((VL_WIDTH + 1)'(1) << lg_cmd) - (VL_WIDTH + 1)'(1));
    nb_d   = VL_WIDTH'(nb_sum >> lg_cmd);
  end

  // Element index of the first element in this beat, and how many elements remain.
  always_comb begin
    prod    = PW'(b_q) << lg_q;
    epb_q   = PW'(1) << lg_q;
    rem     = PW'(vl_q) - prod;
    partial = last_beat && (rem < epb_q);
    nbytes  = (PW + 3)'(rem) << sew_q;
    be_part = '0;
    for (int i = 0; i < BYTES; i++) begin
      be_part[i] = (nbytes > (PW + 3)'(i));
    end
  end

  // Issue-side outputs: all forced to zero outside ISSUE so the unit never sees stale fields.
  always_comb begin
    iss_valid     = in_issue && !iss_stall;
    iss_sew       = '0;
    iss_opSel     = '0;
    iss_avg       = 1'b0;
    iss_addr      = '0;
    iss_start_idx = '0;
    iss_be        = '0;
    iss_req_start = iss_valid && (b_q == '0);
    iss_req_end   = iss_valid && last_beat;
    if (in_issue) begin
      iss_sew   = sew_q;
      iss_opSel = opsel_q;
      iss_avg   = avg_q;
      iss_be    = partial ? be_part : '1;
      if (opsel_q[MASK_BIT]) begin
        // Mask results pack one bit per element: 64 elements share one destination word.
        iss_start_idx = prod[5:0];
        iss_addr      = addr_q + ADDR_WIDTH'(prod >> 6);
      end else begin
        iss_addr = addr_q + ADDR_WIDTH'(b_q);
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      b_q     <= '0;
      nb_q    <= '0;
      dcnt_q  <= '0;
      done_q  <= 1'b0;
      vl_q    <= '0;
      sew_q   <= '0;
      opsel_q <= '0;
      addr_q  <= '0;
      avg_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // abort is not looked at here, so it can never cancel a command being accepted.
          if (accept) begin
            vl_q    <= cmd_vl;
            sew_q   <= cmd_sew;
            opsel_q <= cmd_opSel;
            addr_q  <= cmd_addr;
            avg_q   <= cmd_avg;
            b_q     <= '0;
            nb_q    <= nb_d;
            if (cmd_vl == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (!iss_stall) begin
            if (last_beat) begin
              if (PIPE_LAT <= 1) begin
                done_q  <= 1'b1;
                state_q <= IDLE;
              end else begin
                // Counts the remaining edges so done lands PIPE_LAT cycles after the last beat.
                state_q <= DRAIN;
                dcnt_q  <= DCNT_W'(PIPE_LAT - 1);
              end
            end else begin
              b_q <= b_q + VL_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (dcnt_q <= DCNT_W'(1)) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            dcnt_q <= dcnt_q - DCNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vadd_seq_ctrl.sv
module tb_vadd_seq_ctrl;
  localparam int DW = 64, AW = 32, VW = 16, OW = 9, PL = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [VW-1:0] cmd_vl = '0;
  logic [1:0]    cmd_sew = '0;
  logic [OW-1:0] cmd_opSel = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic          cmd_avg = 1'b0;
  logic          iss_stall = 1'b0;
  logic          abort = 1'b0;
  logic          iss_valid;
  logic [1:0]    iss_sew;
  logic [OW-1:0] iss_opSel;
  logic          iss_avg;
  logic [AW-1:0] iss_addr;
  logic [5:0]    iss_start_idx;
  logic          iss_req_start, iss_req_end;
  logic [DW/8-1:0] iss_be;
  logic          busy, done;

  vadd_seq_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VL_WIDTH(VW), .OPSEL_WIDTH(OW), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_vl(cmd_vl),
    .cmd_sew(cmd_sew), .cmd_opSel(cmd_opSel), .cmd_addr(cmd_addr), .cmd_avg(cmd_avg),
    .iss_stall(iss_stall), .abort(abort), .iss_valid(iss_valid), .iss_sew(iss_sew),
    .iss_opSel(iss_opSel), .iss_avg(iss_avg), .iss_addr(iss_addr), .iss_start_idx(iss_start_idx),
    .iss_req_start(iss_req_start), .iss_req_end(iss_req_end), .iss_be(iss_be),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c; logic [AW-1:0] a; logic [7:0] be; logic [5:0] si;
    logic st, en, av, rdy, bz; logic [1:0] sw; logic [OW-1:0] op;
  } beat_t;
  beat_t beats[$];
  int    dones[$];
  logic  done_rdy[$];
  logic  done_bz[$];

  // Record every issued beat and every done pulse with the cycle it appeared in.
  always @(negedge clk) begin
    if (iss_valid) begin
      beat_t b;
      b.c = cyc; b.a = iss_addr; b.be = iss_be; b.si = iss_start_idx;
      b.st = iss_req_start; b.en = iss_req_end; b.av = iss_avg;
      b.rdy = cmd_ready; b.bz = busy; b.sw = iss_sew; b.op = iss_opSel;
      beats.push_back(b);
    end
    if (done) begin
      dones.push_back(cyc);
      done_rdy.push_back(cmd_ready);
      done_bz.push_back(busy);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    beats.delete(); dones.delete(); done_rdy.delete(); done_bz.delete();
  endtask

  // Offers a command from the current cycle; returns acc = acceptance cycle, one cycle later.
  task automatic send_cmd(input logic [VW-1:0] vl, input logic [1:0] sew, input logic [OW-1:0] op,
                          input logic [AW-1:0] addr, input logic av, output int acc);
    acc = -1;
    cmd_vl = vl; cmd_sew = sew; cmd_opSel = op; cmd_addr = addr; cmd_avg = av; cmd_valid = 1'b1;
    for (int n = 0; n < 50 && acc < 0; n++) begin
      @(negedge clk);
      if (cmd_ready) acc = cyc;
      else step();
    end
    checks++; if (acc < 0) begin errors++; $display("FAIL cmd_accept: got no acceptance want acceptance within 50 cycles"); end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int lim, input string nm);
    int n = 0;
    while (dones.size() == 0 && n < lim) begin @(negedge clk); n++; end
    checks++; if (dones.size() == 0) begin errors++; $display("FAIL %s_done_timeout: got no done want done within %0d cycles", nm, lim); end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL rst_iss_valid: got %b want 0", iss_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (iss_be !== 8'h00) begin errors++; $display("FAIL rst_iss_be: got %h want 00", iss_be); end
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready); end
    step();
  endtask

  // sew=8b, vl=20: three beats, last beat carries four valid bytes.
  task automatic test_basic();
    int acc;
    logic [7:0] ebe [3];
    ebe = '{8'hFF, 8'hFF, 8'h0F};
    clear_logs();
    send_cmd(16'd20, 2'd0, 9'h0A5, 32'h100, 1'b1, acc);
    wait_done(40, "basic");
    repeat (3) step();
    checks++; if (beats.size() != 3) begin errors++; $display("FAIL basic_beats: got %0d want 3", beats.size()); end
    for (int i = 0; i < beats.size() && i < 3; i++) begin
      checks++; if (beats[i].c != acc + 1 + i) begin errors++; $display("FAIL basic_cycle%0d: got %0d want %0d", i, beats[i].c, acc + 1 + i); end
      checks++; if (beats[i].a !== 32'h100 + i) begin errors++; $display("FAIL basic_addr%0d: got %h want %h", i, beats[i].a, 32'h100 + i); end
      checks++; if (beats[i].be !== ebe[i]) begin errors++; $display("FAIL basic_be%0d: got %h want %h", i, beats[i].be, ebe[i]); end
      checks++; if (beats[i].st !== (i == 0)) begin errors++; $display("FAIL basic_start%0d: got %b want %b", i, beats[i].st, (i == 0)); end
      checks++; if (beats[i].en !== (i == 2)) begin errors++; $display("FAIL basic_end%0d: got %b want %b", i, beats[i].en, (i == 2)); end
      checks++; if (beats[i].si !== 6'd0) begin errors++; $display("FAIL basic_sidx%0d: got %0d want 0", i, beats[i].si); end
      checks++; if ({beats[i].sw, beats[i].op, beats[i].av} !== {2'd0, 9'h0A5, 1'b1}) begin errors++; $display("FAIL basic_fields%0d: got %h/%h/%b want 0/0a5/1", i, beats[i].sw, beats[i].op, beats[i].av); end
      checks++; if ({beats[i].rdy, beats[i].bz} !== 2'b01) begin errors++; $display("FAIL basic_rdy_busy%0d: got %b%b want 01", i, beats[i].rdy, beats[i].bz); end
    end
    checks++; if (dones.size() != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", dones.size()); end
    if (dones.size() > 0) begin
      checks++; if (dones[0] != acc + 3 + PL) begin errors++; $display("FAIL basic_done_cycle: got %0d want %0d", dones[0], acc + 3 + PL); end
      checks++; if ({done_rdy[0], done_bz[0]} !== 2'b10) begin errors++; $display("FAIL basic_done_state: got rdy=%b busy=%b want 1/0", done_rdy[0], done_bz[0]); end
    end
  endtask

  // sew=64b, vl=3, one stall cycle after beat 0.
  task automatic test_stall();
    int acc;
    int ec [3];
    clear_logs();
    send_cmd(16'd3, 2'd3, 9'h001, 32'h200, 1'b0, acc);
    step(); iss_stall = 1'b1;
    step(); iss_stall = 1'b0;
    ec = '{acc + 1, acc + 3, acc + 4};
    wait_done(40, "stall");
    repeat (3) step();
    checks++; if (beats.size() != 3) begin errors++; $display("FAIL stall_beats: got %0d want 3", beats.size()); end
    for (int i = 0; i < beats.size() && i < 3; i++) begin
      checks++; if (beats[i].c != ec[i]) begin errors++; $display("FAIL stall_cycle%0d: got %0d want %0d", i, beats[i].c, ec[i]); end
      checks++; if (beats[i].a !== 32'h200 + i) begin errors++; $display("FAIL stall_addr%0d: got %h want %h", i, beats[i].a, 32'h200 + i); end
      checks++; if (beats[i].be !== 8'hFF) begin errors++; $display("FAIL stall_be%0d: got %h want ff", i, beats[i].be); end
    end
    checks++; if (dones.size() != 1 || dones[0] != acc + 4 + PL) begin errors++; $display("FAIL stall_done: got count %0d first %0d want 1 at %0d", dones.size(), (dones.size() > 0) ? dones[0] : -1, acc + 4 + PL); end
  endtask

  // Mask compare, sew=8b, vl=200: 25 beats, eight beats per mask word.
  task automatic test_mask();
    int acc;
    clear_logs();
    send_cmd(16'd200, 2'd0, 9'h100, 32'h40, 1'b0, acc);
    wait_done(80, "mask");
    repeat (3) step();
    checks++; if (beats.size() != 25) begin errors++; $display("FAIL mask_beats: got %0d want 25", beats.size()); end
    for (int i = 0; i < beats.size() && i < 25; i++) begin
      checks++; if (beats[i].c != acc + 1 + i) begin errors++; $display("FAIL mask_cycle%0d: got %0d want %0d", i, beats[i].c, acc + 1 + i); end
      checks++; if (beats[i].si != (i * 8) % 64) begin errors++; $display("FAIL mask_sidx%0d: got %0d want %0d", i, beats[i].si, (i * 8) % 64); end
      checks++; if (beats[i].a !== 32'h40 + (i / 8)) begin errors++; $display("FAIL mask_addr%0d: got %h want %h", i, beats[i].a, 32'h40 + (i / 8)); end
      checks++; if (beats[i].be !== 8'hFF) begin errors++; $display("FAIL mask_be%0d: got %h want ff", i, beats[i].be); end
      checks++; if ({beats[i].st, beats[i].en} !== {(i == 0), (i == 24)}) begin errors++; $display("FAIL mask_startend%0d: got %b%b want %b%b", i, beats[i].st, beats[i].en, (i == 0), (i == 24)); end
    end
    checks++; if (dones.size() != 1 || dones[0] != acc + 25 + PL) begin errors++; $display("FAIL mask_done: got count %0d first %0d want 1 at %0d", dones.size(), (dones.size() > 0) ? dones[0] : -1, acc + 25 + PL); end
  endtask

  task automatic test_vl_zero();
    int acc;
    clear_logs();
    send_cmd(16'd0, 2'd0, 9'h000, 32'h80, 1'b0, acc);
    repeat (8) step();
    checks++; if (beats.size() != 0) begin errors++; $display("FAIL vl0_beats: got %0d want 0", beats.size()); end
    checks++; if (dones.size() != 1) begin errors++; $display("FAIL vl0_done_count: got %0d want 1", dones.size()); end
    if (dones.size() > 0) begin
      checks++; if (dones[0] != acc + 1) begin errors++; $display("FAIL vl0_done_cycle: got %0d want %0d", dones[0], acc + 1); end
      checks++; if ({done_rdy[0], done_bz[0]} !== 2'b10) begin errors++; $display("FAIL vl0_done_state: got rdy=%b busy=%b want 1/0", done_rdy[0], done_bz[0]); end
    end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL vl0_ready: got %b want 1", cmd_ready); end
  endtask

  // Single partial beat: start and end together, three bytes enabled.
  task automatic test_one_beat();
    int acc;
    clear_logs();
    send_cmd(16'd3, 2'd0, 9'h002, 32'hFFFF_FFFF, 1'b0, acc);
    wait_done(40, "one");
    repeat (2) step();
    checks++; if (beats.size() != 1) begin errors++; $display("FAIL one_beats: got %0d want 1", beats.size()); end
    if (beats.size() > 0) begin
      checks++; if ({beats[0].st, beats[0].en, beats[0].be} !== {1'b1, 1'b1, 8'h07}) begin errors++; $display("FAIL one_beat_fields: got %b%b be=%h want 11 be=07", beats[0].st, beats[0].en, beats[0].be); end
    end
    checks++; if (dones.size() != 1 || dones[0] != acc + 1 + PL) begin errors++; $display("FAIL one_done: got count %0d first %0d want 1 at %0d", dones.size(), (dones.size() > 0) ? dones[0] : -1, acc + 1 + PL); end
  endtask

  // Abort on beat 1, then a new command offered immediately while abort is still high.
  task automatic test_abort();
    int acc, acc2;
    logic [7:0] ebe [2];
    ebe = '{8'hFF, 8'h03};
    clear_logs();
    send_cmd(16'd24, 2'd0, 9'h000, 32'h300, 1'b0, acc);
    step(); abort = 1'b1;
    step();
    checks++; if ({busy, cmd_ready} !== 2'b01) begin errors++; $display("FAIL abort_idle: got busy=%b rdy=%b want 0/1", busy, cmd_ready); end
    clear_logs();
    send_cmd(16'd5, 2'd1, 9'h000, 32'h500, 1'b0, acc2);
    abort = 1'b0;
    checks++; if (acc2 != acc + 3) begin errors++; $display("FAIL abort_reaccept: got %0d want %0d", acc2, acc + 3); end
    wait_done(40, "abort");
    repeat (4) step();
    checks++; if (beats.size() != 2) begin errors++; $display("FAIL abort_beats: got %0d want 2", beats.size()); end
    for (int i = 0; i < beats.size() && i < 2; i++) begin
      checks++; if (beats[i].c != acc2 + 1 + i || beats[i].a !== 32'h500 + i) begin errors++; $display("FAIL abort_beat%0d: got cyc %0d addr %h want cyc %0d addr %h", i, beats[i].c, beats[i].a, acc2 + 1 + i, 32'h500 + i); end
      checks++; if (beats[i].be !== ebe[i]) begin errors++; $display("FAIL abort_be%0d: got %h want %h", i, beats[i].be, ebe[i]); end
    end
    checks++; if (dones.size() != 1 || dones[0] != acc2 + 2 + PL) begin errors++; $display("FAIL abort_done: got count %0d first %0d want 1 at %0d", dones.size(), (dones.size() > 0) ? dones[0] : -1, acc2 + 2 + PL); end
  endtask

  task automatic test_reset_mid();
    int acc;
    clear_logs();
    send_cmd(16'd40, 2'd2, 9'h1C3, 32'h600, 1'b1, acc);
    step();
    rst = 1'b1;
    #1;
    checks++; if ({iss_valid, busy, done, cmd_ready, iss_req_start, iss_req_end, iss_avg} !== 7'b0) begin errors++; $display("FAIL rstmid_ctrl: got %b%b%b%b%b%b%b want 0000000", iss_valid, busy, done, cmd_ready, iss_req_start, iss_req_end, iss_avg); end
    checks++; if ({iss_addr, iss_be, iss_start_idx, iss_sew, iss_opSel} !== '0) begin errors++; $display("FAIL rstmid_fields: got addr=%h be=%h sidx=%0d sew=%0d op=%h want all 0", iss_addr, iss_be, iss_start_idx, iss_sew, iss_opSel); end
    step(); step();
    rst = 1'b0;
    clear_logs();
    repeat (20) step();
    checks++; if (dones.size() != 0 || beats.size() != 0) begin errors++; $display("FAIL rstmid_discard: got dones=%0d beats=%0d want 0/0", dones.size(), beats.size()); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", cmd_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_mask();
    test_vl_zero();
    test_one_beat();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish before 200000 time units");
    $fatal(1, "timeout");
  end
endmodule
